cle_key_reader: RTL and testbench
=================================

Name: cle_key_reader

Overview:
- Host-side sequencer that drives the CLE28e key/ID state machine (6-bit registered sequencer, serial SDRD output) as a bus master.
- On `start`, it issues a programmable unlock sequence of qualified write strobes, then ID_BITS read strobes.
- On each read strobe it samples SDRD and shifts the bit into an ID word. When the sequence ends it compares the word against an expected value.
- Sits directly downstream of the key device and upstream of the boot/licence check logic.

Parameters:
- ID_BITS, 16, number of SDRD bits read (1..32).
- UNLOCK_LEN, 4, number of unlock accesses (1..8).
- UNLOCK_SEQ, 32'h0000_28A9, packed BA7..BA4 nibbles. Nibble 0 (bits 3:0) is issued first; only the low UNLOCK_LEN nibbles are used.
- READ_NIB, 4'h0, BA7..BA4 value driven during read accesses.
- STROBE_W, 2, clocks `key_clk` stays high per access (>=1).
- EXPECT_ID, 16'hC35A, value compared against the assembled ID (width ID_BITS).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a sequence; single-cycle pulse; ignored while busy
- busy  out  1  high from the first setup clock until done
- done  out  1  one-clock pulse at end of sequence
- id_word  out  ID_BITS  assembled ID, MSB = first bit read; held until next start
- match  out  1  id_word == EXPECT_ID; valid from done, held until next start
- ba13  out  1  driven 0 during accesses
- ba12  out  1  driven 1 during accesses
- ba7_4  out  4  access nibble
- sser_n  out  1  active-low key select
- br_w  out  1  driven 1 during every access
- key_clk  out  1  clock/strobe to key device; its rising edge advances device state
- sdrd  in  1  serial data from key device (valid whenever sser_n=0 and the access is a read)

Behaviour:
- Reset (asynchronous, active-high) drives every output to its idle value:
  - `busy`=0, `done`=0, `id_word`=0, `match`=0
  - `sser_n`=1, `key_clk`=0
  - `ba13`=0, `ba12`=0, `ba7_4`=0, `br_w`=0
  - FSM = IDLE, all counters = 0.
- Assertion mid-sequence aborts immediately; no partial `done`. The next `start` reruns the full unlock sequence.
- FSM states: IDLE, SETUP, STROBE, HOLD, FINISH.
- IDLE:
  - `start`=1 at an edge → SETUP; `busy`=1.
  - `id_word` and `match` are cleared to 0 on that same edge.
  - Access index = 0.
- SETUP (1 clk):
  - Drives `sser_n`=0, `ba13`=0, `ba12`=1, `br_w`=1.
  - `ba7_4` = UNLOCK_SEQ nibble[idx] while idx < UNLOCK_LEN, else READ_NIB.
  - If idx >= UNLOCK_LEN: sample `sdrd` on the edge leaving SETUP and do id_word <= {id_word[ID_BITS-2:0], sdrd}.
  - → STROBE.
- STROBE (STROBE_W clks):
  - `key_clk`=1; address and select held stable.
  - Exits to HOLD after the strobe-width counter expires.
- HOLD (1 clk):
  - `key_clk`=0; address and select still held.
  - idx++.
  - If idx was the last (UNLOCK_LEN+ID_BITS-1) → FINISH, else → SETUP.
- Address/select are stable across all SETUP, STROBE and HOLD clocks of an access. They never change while `key_clk`=1.
- FINISH (1 clk):
  - `done`=1, `busy`=0, `sser_n`=1.
  - Bus returns to idle values.
  - `match` registered from the final `id_word`.
  - → IDLE.
- Access length = STROBE_W+2 clocks.
- Latency: with `start` sampled at edge E0, `done` is high between E(N) and E(N+1), where N = (UNLOCK_LEN+ID_BITS)*(STROBE_W+2). Defaults give N = 80.
- `start` while busy (including the FINISH clock) is ignored. A `start` on the clock after FINISH is accepted.
- The index counter is wide enough for UNLOCK_LEN+ID_BITS with no wrap; the strobe counter is sized for STROBE_W.
- No back-to-back gap is required between accesses: HOLD → SETUP directly.

Decomposition:
- Shared package cle_key_pkg:
  - FSM state enum.
  - Access-type constants (ACC_UNLOCK, ACC_READ).
  - Bus idle-value constants.
  - Default UNLOCK_SEQ / EXPECT_ID.
- One sub-module, cle_key_access:
  - Owns the SETUP/STROBE/HOLD timing for a single access.
  - Interface: req/nibble/is_read in; sample_pulse/ack out; drives key_clk/sser_n.
- The top level owns the index counter, unlock/read selection, shift register and compare.

Test Plan:
- Reset idle: rst=1 for 3 clks, release → `sser_n`=1, `key_clk`=0, `busy`=0, `id_word`=0, `match`=0, bus pins 0.
- Nominal read:
  - Stimulus: device model returning bits of 16'hC35A MSB-first after the correct unlock; `start` pulse.
  - Unlock nibbles observed on `ba7_4`: 9, A, 8, 2.
  - Response: `done` exactly 80 clks after `start`; `id_word`=16'hC35A, `match`=1.
- Mismatch: model returns 16'hC35B → `done` at 80 clks, `id_word`=16'hC35B, `match`=0.
- Strobe timing (STROBE_W=3): each access is 5 clks; `key_clk` high for 3; `ba7_4`/`sser_n` never change while `key_clk`=1; `done` at 100 clks.
- Ignored start: second `start` pulses at clk 10 and at the FINISH clock → exactly one `done`; the sequence is not restarted.
- Reset mid-op: assert rst at clk 37 → all outputs idle the same cycle with no `done`. A new `start` yields full unlock + 16 reads and the correct `id_word`.

Source files
------------

// File: rtl/cle_key_reader_pkg.sv
// Shared types and constants for the CLE28e key/ID reader: state encodings,
// access-type codes, bus idle/active values and default key parameters.
package cle_key_pkg;

   // Combined view of the reader's progress, as seen on the debug port.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_STROBE = 3'd2,
      ST_HOLD   = 3'd3,
      ST_FINISH = 3'd4
   } key_state_e;

   // Top-level sequencer states; the access engine supplies the
   // SETUP/STROBE/HOLD detail while the sequencer is in SEQ_RUN.
   typedef enum logic [1:0] {
      SEQ_IDLE   = 2'd0,
      SEQ_RUN    = 2'd1,
      SEQ_FINISH = 2'd2
   } seq_state_e;

   // Access type carried on the is_read line of an access request.
   localparam logic ACC_UNLOCK = 1'b0;
   localparam logic ACC_READ   = 1'b1;

   // Address/select pins driven towards the key device.
   typedef struct packed {
      logic       ba13;
      logic       ba12;
      logic [3:0] ba7_4;
      logic       sser_n;
      logic       br_w;
   } key_bus_t;

   localparam key_bus_t BUS_IDLE = '{ba13: 1'b0, ba12: 1'b0, ba7_4: 4'h0,
                                     sser_n: 1'b1, br_w: 1'b0};

   localparam logic [31:0] DEF_UNLOCK_SEQ = 32'h0000_28A9;
   localparam logic [31:0] DEF_EXPECT_ID  = 32'h0000_C35A;

   // Bus value for an access to the given BA7..BA4 nibble.
   function automatic key_bus_t bus_active(input logic [3:0] nib);
      key_bus_t b;
      b.ba13   = 1'b0;
      b.ba12   = 1'b1;
      b.ba7_4  = nib;
      b.sser_n = 1'b0;
      b.br_w   = 1'b1;
      return b;
   endfunction

   // Nibble idx of a packed unlock sequence (nibble 0 in bits 3:0).
   function automatic logic [3:0] unlock_nibble(input logic [31:0] seq,
                                                input int unsigned idx);
      logic [3:0] nib;
      nib = 4'h0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (idx == i) nib = seq[4*i +: 4];
      end
      return nib;
   endfunction

endpackage

// File: rtl/cle_key_reader_if.sv
// Pin bundle between the reader (master) and the CLE28e key device (slave).
interface cle_key_reader_if;
   logic       ba13;
   logic       ba12;
   logic [3:0] ba7_4;
   logic       sser_n;
   logic       br_w;
   logic       key_clk;
   logic       sdrd;

   modport master (output ba13, ba12, ba7_4, sser_n, br_w, key_clk,
                   input  sdrd);
   modport slave  (input  ba13, ba12, ba7_4, sser_n, br_w, key_clk,
                   output sdrd);
endinterface

// File: rtl/cle_key_reader_access.sv
// Timing engine for one key-device access: SETUP (1 clk), STROBE (STROBE_W
// clks with key_clk high), HOLD (1 clk). Address/select are loaded on entry
// to SETUP and stay put until the access ends, so they never move while
// key_clk is high.
//
// Request protocol: req is sampled in IDLE and in the HOLD clock. ack is a
// one-clock pulse during HOLD; a req seen in that same clock chains the next
// access straight into SETUP with no gap. sample_pulse is high for the SETUP
// clock of a read access; the consumer captures sdrd on the edge ending it.
module cle_key_access
   import cle_key_pkg::*;
#(
   parameter int STROBE_W = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   input  logic [3:0] nibble,
   input  logic       is_read,
   output logic       sample_pulse,
   output logic       ack,
   output logic       key_clk,
   output key_bus_t   bus,
   output key_state_e state
);

   localparam int CNT_W = (STROBE_W > 1) ? $clog2(STROBE_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STROBE_W - 1);

   logic [CNT_W-1:0] cnt;

   // Access FSM with registered bus, strobe and handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         bus          <= BUS_IDLE;
         key_clk      <= 1'b0;
         sample_pulse <= 1'b0;
         ack          <= 1'b0;
      end else begin
         sample_pulse <= 1'b0;
         ack          <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req) begin
                  state        <= ST_SETUP;
                  bus          <= bus_active(nibble);
                  sample_pulse <= (is_read == ACC_READ);
               end
            end
            ST_SETUP: begin
               state   <= ST_STROBE;
               key_clk <= 1'b1;
               cnt     <= '0;
            end
            ST_STROBE: begin
               if (cnt == CNT_LAST) begin
                  state   <= ST_HOLD;
                  key_clk <= 1'b0;
                  ack     <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_HOLD: begin
               if (req) begin
                  state        <= ST_SETUP;
                  bus          <= bus_active(nibble);
                  sample_pulse <= (is_read == ACC_READ);
               end else begin
                  state <= ST_IDLE;
                  bus   <= BUS_IDLE;
               end
            end
            default: begin
               state   <= ST_IDLE;
               bus     <= BUS_IDLE;
               key_clk <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/cle_key_reader.sv
// Host-side sequencer for the CLE28e key/ID device. On start it issues the
// unlock accesses, then ID_BITS read accesses, shifting SDRD into id_word
// MSB-first, and finally flags whether the word equals EXPECT_ID.
module cle_key_reader
   import cle_key_pkg::*;
#(
   parameter int                 ID_BITS    = 16,
   parameter int                 UNLOCK_LEN = 4,
   parameter logic [31:0]        UNLOCK_SEQ = DEF_UNLOCK_SEQ,
   parameter logic [3:0]         READ_NIB   = 4'h0,
   parameter int                 STROBE_W   = 2,
   parameter logic [ID_BITS-1:0] EXPECT_ID  = DEF_EXPECT_ID[ID_BITS-1:0]
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic [ID_BITS-1:0] id_word,
   output logic               match,
   cle_key_reader_if.master   bus,
   output key_state_e         dbg_state
);

   localparam int TOTAL = UNLOCK_LEN + ID_BITS;
   localparam int IDX_W = $clog2(TOTAL + 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(TOTAL - 1);
   localparam logic [IDX_W-1:0] UNLOCK_NB = IDX_W'(UNLOCK_LEN);

   seq_state_e       seq_state;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] req_idx;
   logic             acc_req;
   logic             acc_is_read;
   logic [3:0]       acc_nibble;
   logic             acc_sample;
   logic             acc_ack;
   logic             acc_key_clk;
   key_bus_t         acc_bus;
   key_state_e       acc_state;

   // Next access request: the first one straight from start, then one per
   // HOLD clock until the last index has been issued.
   always_comb begin
      acc_req = 1'b0;
      req_idx = '0;
      if (seq_state == SEQ_IDLE) begin
         acc_req = start;
      end else if (seq_state == SEQ_RUN && acc_ack && idx != LAST_IDX) begin
         acc_req = 1'b1;
         req_idx = idx + 1'b1;
      end
      acc_is_read = (req_idx >= UNLOCK_NB) ? ACC_READ : ACC_UNLOCK;
      acc_nibble  = (acc_is_read == ACC_READ) ? READ_NIB
                                              : unlock_nibble(UNLOCK_SEQ, 32'(req_idx));
   end

   cle_key_access #(
      .STROBE_W (STROBE_W)
   ) u_access (
      .clk          (clk),
      .rst          (rst),
      .req          (acc_req),
      .nibble       (acc_nibble),
      .is_read      (acc_is_read),
      .sample_pulse (acc_sample),
      .ack          (acc_ack),
      .key_clk      (acc_key_clk),
      .bus          (acc_bus),
      .state        (acc_state)
   );

   assign bus.ba13    = acc_bus.ba13;
   assign bus.ba12    = acc_bus.ba12;
   assign bus.ba7_4   = acc_bus.ba7_4;
   assign bus.sser_n  = acc_bus.sser_n;
   assign bus.br_w    = acc_bus.br_w;
   assign bus.key_clk = acc_key_clk;

   // Sequencer FSM: index counter, ID shift register, done pulse and compare.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seq_state <= SEQ_IDLE;
         idx       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         id_word   <= '0;
         match     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (seq_state)
            SEQ_IDLE: begin
               if (start) begin
                  seq_state <= SEQ_RUN;
                  busy      <= 1'b1;
                  id_word   <= '0;
                  match     <= 1'b0;
                  idx       <= '0;
               end
            end
            SEQ_RUN: begin
               if (acc_sample) begin
                  id_word <= (id_word << 1) | ID_BITS'(bus.sdrd);
               end
               if (acc_ack) begin
                  if (idx == LAST_IDX) begin
                     seq_state <= SEQ_FINISH;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     match     <= (id_word == EXPECT_ID);
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            SEQ_FINISH: begin
               seq_state <= SEQ_IDLE;
               idx       <= '0;
            end
            default: begin
               seq_state <= SEQ_IDLE;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   // Debug view: access-level detail while running, else sequencer state.
   always_comb begin
      dbg_state = ST_IDLE;
      if (seq_state == SEQ_RUN)         dbg_state = acc_state;
      else if (seq_state == SEQ_FINISH) dbg_state = ST_FINISH;
   end

endmodule

// File: tb/tb_cle_key_reader.sv
// Directed bench for cle_key_reader: a behavioural key device per DUT
// instance (default strobe width and STROBE_W=3), idle/reset checks,
// nominal and mismatching IDs, ignored starts and an abort by reset.
module tb_cle_key_reader;
   import cle_key_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start0 = 1'b0;
   logic start1 = 1'b0;
   logic dev_clr = 1'b0;

   logic        busy0, done0, match0, busy1, done1, match1;
   logic [15:0] id0, id1;
   key_state_e  st0, st1;

   logic [15:0] dev_id [2];
   logic        kc [2];
   logic [3:0]  nib [2];
   logic        ssn [2];
   logic        sd [2];
   logic        dn [2];

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   int lat;

   // clock / reset
   always #5 clk = ~clk;

   cle_key_reader_if bus0 ();
   cle_key_reader_if bus1 ();

   cle_key_reader u_dut0 (
      .clk (clk), .rst (rst), .start (start0), .busy (busy0), .done (done0),
      .id_word (id0), .match (match0), .bus (bus0), .dbg_state (st0)
   );

   cle_key_reader #(.STROBE_W (3)) u_dut1 (
      .clk (clk), .rst (rst), .start (start1), .busy (busy1), .done (done1),
      .id_word (id1), .match (match1), .bus (bus1), .dbg_state (st1)
   );

   assign kc[0]  = bus0.key_clk;
   assign kc[1]  = bus1.key_clk;
   assign nib[0] = bus0.ba7_4;
   assign nib[1] = bus1.ba7_4;
   assign ssn[0] = bus0.sser_n;
   assign ssn[1] = bus1.sser_n;
   assign dn[0]  = done0;
   assign dn[1]  = done1;
   assign bus0.sdrd = sd[0];
   assign bus1.sdrd = sd[1];

   for (genvar g = 0; g < 2; g++) begin : g_dev
      localparam int W = (g == 0) ? 2 : 3;
      logic [15:0] unl_ref = 16'h28A9;
      logic [3:0]  acc_cnt;
      logic [5:0]  rd_cnt;
      logic        bad;
      logic [15:0] seen_unl;
      int          hi_len;
      int          strobe_err;
      int          done_cnt;
      logic [3:0]  nib_lat;
      logic        ssn_lat;

      // Device state advances on each rising key_clk with select active.
      always @(posedge kc[g] or posedge dev_clr) begin
         if (dev_clr) begin
            acc_cnt  <= 4'd0;
            rd_cnt   <= 6'd0;
            bad      <= 1'b0;
            seen_unl <= 16'h0;
         end else if (!ssn[g]) begin
            if (acc_cnt < 4'd4) begin
               seen_unl[4*acc_cnt +: 4] <= nib[g];
               if (nib[g] != unl_ref[4*acc_cnt +: 4]) bad <= 1'b1;
               acc_cnt <= acc_cnt + 4'd1;
            end else begin
               if (nib[g] != 4'h0) bad <= 1'b1;
               rd_cnt <= rd_cnt + 6'd1;
            end
         end
      end

      // ID bits are presented MSB-first only after a correct unlock.
      assign sd[g] = (!bad && acc_cnt == 4'd4 && rd_cnt < 6'd16) ?
                     dev_id[g][4'd15 - rd_cnt[3:0]] : 1'b0;

      // Strobe width / address stability monitor and done counter.
      always @(negedge clk or posedge dev_clr) begin
         if (dev_clr) begin
            hi_len     <= 0;
            strobe_err <= 0;
            done_cnt   <= 0;
            nib_lat    <= 4'h0;
            ssn_lat    <= 1'b1;
         end else begin
            if (dn[g]) done_cnt <= done_cnt + 1;
            if (kc[g]) begin
               if (hi_len == 0) begin
                  nib_lat <= nib[g];
                  ssn_lat <= ssn[g];
               end else if (nib[g] != nib_lat || ssn[g] != ssn_lat) begin
                  strobe_err <= strobe_err + 1;
               end
               hi_len <= hi_len + 1;
            end else if (hi_len != 0) begin
               if (hi_len != W || nib[g] != nib_lat || ssn[g] != ssn_lat)
                  strobe_err <= strobe_err + 1;
               hi_len <= 0;
            end
         end
      end
   end

   // driver tasks
   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_dev();
      dev_clr = 1'b1;
      #1;
      dev_clr = 1'b0;
   endtask

   // Pulse start so that it is sampled on the next edge (E0); returns at E0+1.
   task automatic start_pulse(input int inst);
      @(posedge clk);
      #1;
      if (inst == 0) start0 = 1'b1;
      else           start1 = 1'b1;
      @(posedge clk);
      #1;
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   // Count edges after E0 until done is seen; 0 if it never arrives.
   task automatic wait_done(input int inst, output int cycles);
      cycles = 0;
      for (int k = 1; k <= 300; k++) begin
         @(posedge clk);
         @(negedge clk);
         if ((inst == 0 && done0) || (inst == 1 && done1)) begin
            cycles = k;
            break;
         end
      end
   endtask

   task automatic check_idle0(input string tag);
      chk({tag, "_busy"},   32'(busy0),       32'd0);
      chk({tag, "_done"},   32'(done0),       32'd0);
      chk({tag, "_sser_n"}, 32'(bus0.sser_n), 32'd1);
      chk({tag, "_keyclk"}, 32'(bus0.key_clk),32'd0);
      chk({tag, "_ba13"},   32'(bus0.ba13),   32'd0);
      chk({tag, "_ba12"},   32'(bus0.ba12),   32'd0);
      chk({tag, "_ba7_4"},  32'(bus0.ba7_4),  32'd0);
      chk({tag, "_br_w"},   32'(bus0.br_w),   32'd0);
      chk({tag, "_id"},     32'(id0),         32'd0);
      chk({tag, "_match"},  32'(match0),      32'd0);
      chk({tag, "_state"},  32'(st0),         32'(ST_IDLE));
   endtask

   // directed sequence
   initial begin
      dev_id[0] = 16'hC35A;
      dev_id[1] = 16'hC35A;
      clear_dev();

      // reset held for 3 clocks, then idle outputs
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_idle0("reset");
      chk("reset_sser_n1", 32'(bus1.sser_n), 32'd1);

      // nominal read, default strobe width
      clear_dev();
      start_pulse(0);
      @(negedge clk);
      chk("nom_busy_setup", 32'(busy0), 32'd1);
      chk("nom_ba12_setup", 32'(bus0.ba12), 32'd1);
      chk("nom_first_nib",  32'(bus0.ba7_4), 32'h9);
      wait_done(0, lat);
      chk("nom_latency", 32'(lat), 32'd80);
      chk("nom_busy_done", 32'(busy0), 32'd0);
      chk("nom_sser_done", 32'(bus0.sser_n), 32'd1);
      chk("nom_id", 32'(id0), 32'hC35A);
      chk("nom_match", 32'(match0), 32'd1);
      chk("nom_unlock_nibs", 32'(g_dev[0].seen_unl), 32'h28A9);
      chk("nom_reads", 32'(g_dev[0].rd_cnt), 32'd16);
      @(negedge clk);
      chk("nom_done_pulse", 32'(done0), 32'd0);
      chk("nom_match_held", 32'(match0), 32'd1);
      chk("nom_strobe", 32'(g_dev[0].strobe_err), 32'd0);
      chk("nom_done_cnt", 32'(g_dev[0].done_cnt), 32'd1);

      // mismatching ID
      dev_id[0] = 16'hC35B;
      clear_dev();
      start_pulse(0);
      @(negedge clk);
      chk("mis_id_cleared", 32'(id0), 32'd0);
      chk("mis_match_cleared", 32'(match0), 32'd0);
      wait_done(0, lat);
      chk("mis_latency", 32'(lat), 32'd80);
      chk("mis_id", 32'(id0), 32'hC35B);
      chk("mis_match", 32'(match0), 32'd0);

      // strobe width 3
      clear_dev();
      start_pulse(1);
      wait_done(1, lat);
      chk("w3_latency", 32'(lat), 32'd100);
      chk("w3_id", 32'(id1), 32'hC35A);
      chk("w3_match", 32'(match1), 32'd1);
      chk("w3_unlock_nibs", 32'(g_dev[1].seen_unl), 32'h28A9);
      @(negedge clk);
      chk("w3_strobe", 32'(g_dev[1].strobe_err), 32'd0);

      // starts at clk 10 and during FINISH are ignored
      dev_id[0] = 16'hC35A;
      clear_dev();
      start_pulse(0);
      lat = 0;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk);
         #1 start0 = (k == 9 || k == 80);
         @(negedge clk);
         if (done0 && lat == 0) lat = k;
      end
      start0 = 1'b0;
      chk("ign_latency", 32'(lat), 32'd80);
      chk("ign_done_cnt", 32'(g_dev[0].done_cnt), 32'd1);
      chk("ign_busy", 32'(busy0), 32'd0);
      chk("ign_id", 32'(id0), 32'hC35A);
      chk("ign_reads", 32'(g_dev[0].rd_cnt), 32'd16);

      // reset at clk 37 aborts without done, then a full rerun
      clear_dev();
      start_pulse(0);
      repeat (36) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check_idle0("abort");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_no_done", 32'(g_dev[0].done_cnt), 32'd0);
      clear_dev();
      start_pulse(0);
      wait_done(0, lat);
      chk("rerun_latency", 32'(lat), 32'd80);
      chk("rerun_id", 32'(id0), 32'hC35A);
      chk("rerun_match", 32'(match0), 32'd1);
      chk("rerun_unlock_nibs", 32'(g_dev[0].seen_unl), 32'h28A9);

      // final report
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
